// File: rtl/cga_pixel_sequencer.sv
// CGA graphics-mode pixel sequencer: byte handshake, 320/640 serialiser, colour mapping, border/disable.
// Optional CGA_MODE5_PALETTE_EN: in 320 mode with mode[2]=1, pixels 1-3 use the cyan/red/white palette.
module cga_pixel_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       bus_a,
    input  logic       bus_wr,
    input  logic [7:0] bus_d,
    input  logic       pix_ce,
    input  logic       display_enable,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [3:0] video,
    output logic       underrun
);

    logic [5:0] mode_q, mode_d;
    logic [5:0] colsel_q, colsel_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] sr_q, sr_d;
    logic [3:0] pcnt_q, pcnt_d;
    logic       phase_q, phase_d;
    logic [3:0] video_q, video_d;
    logic       underrun_q, underrun_d;
    logic       de_q, de_d;

    logic       gfx, hires, accept, step, consume, load, pix_ok;
    logic [3:0] border, pix_color;
    logic [1:0] pix_bits;
    logic [7:0] src;
    logic       unused_mode_bits;

    assign gfx        = mode_q[1];
    assign hires      = mode_q[4];
    assign byte_ready = gfx & ~hold_full_q;
    assign video      = video_q;
    assign underrun   = underrun_q;
    assign unused_mode_bits = ^{mode_q[5], mode_q[2], mode_q[0]};

    // Colour of the pixel currently being shifted out.
    always_comb begin
        pix_color = 4'd0;
        if (hires) begin
            pix_color = pix_bits[0] ? colsel_q[3:0] : 4'd0;
        end else if (pix_bits == 2'd0) begin
            pix_color = colsel_q[3:0];
        end else begin
            pix_color = {colsel_q[4], pix_bits, colsel_q[5]};
`ifdef CGA_MODE5_PALETTE_EN
            if (mode_q[2]) begin
                case (pix_bits)
                    2'd1:    pix_color = {colsel_q[4], 3'd3};
                    2'd2:    pix_color = {colsel_q[4], 3'd4};
                    default: pix_color = {colsel_q[4], 3'd7};
                endcase
            end
`endif
        end
    end

    always_comb begin
        mode_d      = mode_q;
        colsel_d    = colsel_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        sr_d        = sr_q;
        pcnt_d      = pcnt_q;
        phase_d     = phase_q;
        video_d     = video_q;
        underrun_d  = underrun_q;
        de_d        = display_enable;
        load        = 1'b0;
        pix_ok      = 1'b0;
        pix_bits    = 2'd0;
        src         = sr_q;

        border  = hires ? 4'd0 : colsel_q[3:0];
        accept  = byte_valid & byte_ready;
        step    = pix_ce & display_enable & gfx;
        consume = step & (hires | ~phase_q);

        if (step && !hires) begin
            phase_d = ~phase_q;
        end

        if (consume) begin
            if (pcnt_q != 4'd0) begin
                pix_ok = 1'b1;
                pcnt_d = pcnt_q - 4'd1;
            end else if (hold_full_q) begin
                // Reload and emit the MSB pixel in the same step.
                src    = hold_q;
                load   = 1'b1;
                pix_ok = 1'b1;
                pcnt_d = hires ? 4'd7 : 4'd3;
            end else begin
                underrun_d = 1'b1;
            end
            if (pix_ok) begin
                pix_bits = hires ? {1'b0, src[7]} : src[7:6];
                sr_d     = hires ? {src[6:0], 1'b0} : {src[5:0], 2'b00};
            end
        end

        if (load) begin
            hold_full_d = 1'b0;
        end
        if (accept) begin
            hold_d      = byte_data;
            hold_full_d = 1'b1;
        end

        if (consume) begin
            video_d = pix_ok ? pix_color : border;
        end
        if (!display_enable || !gfx) begin
            video_d = border;
        end
        if (!mode_q[3]) begin
            video_d = 4'd0;
        end

        // End of active line drops any partially shifted byte.
        if (de_q && !display_enable) begin
            pcnt_d  = 4'd0;
            phase_d = 1'b0;
        end

        if (bus_wr && !bus_a) begin
            mode_d = bus_d[5:0];
            if (bus_d[4] != mode_q[4]) begin
                pcnt_d  = 4'd0;
                phase_d = 1'b0;
            end
            if (mode_q[1] && !bus_d[1]) begin
                hold_full_d = 1'b0;
                pcnt_d      = 4'd0;
                phase_d     = 1'b0;
            end
        end
        if (bus_wr && bus_a) begin
            colsel_d = bus_d[5:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= 6'd0;
            colsel_q    <= 6'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            sr_q        <= 8'd0;
            pcnt_q      <= 4'd0;
            phase_q     <= 1'b0;
            video_q     <= 4'd0;
            underrun_q  <= 1'b0;
            de_q        <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            colsel_q    <= colsel_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            sr_q        <= sr_d;
            pcnt_q      <= pcnt_d;
            phase_q     <= phase_d;
            video_q     <= video_d;
            underrun_q  <= underrun_d;
            de_q        <= de_d;
        end
    end

endmodule

// File: tb/tb_cga_pixel_sequencer.sv
// Scoreboarded bench for cga_pixel_sequencer: directed pixel tables, border, underrun and streaming.
module tb_cga_pixel_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bus_a = 1'b0;
    logic       bus_wr = 1'b0;
    logic [7:0] bus_d = 8'd0;
    logic       pix_ce = 1'b0;
    logic       display_enable = 1'b0;
    logic [7:0] byte_data = 8'd0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [3:0] video;
    logic       underrun;

    logic [3:0] exp_q[$];
    logic       mon_en = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         acc_cnt = 0;

    cga_pixel_sequencer dut (
        .clk(clk), .reset(reset), .bus_a(bus_a), .bus_wr(bus_wr), .bus_d(bus_d),
        .pix_ce(pix_ce), .display_enable(display_enable), .byte_data(byte_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .video(video), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_valid && byte_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1);
    end

    // Monitor: every pixel step inside a checked burst pops one expected colour.
    initial begin
        logic       p;
        logic [3:0] e;
        forever begin
            @(posedge clk);
            p = pix_ce && display_enable && mon_en;
            @(negedge clk);
            if (p) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pixel_unexpected: act=%0h req=<none queued>", video);
                end else begin
                    e = exp_q.pop_front();
                    if (video !== e) begin
                        n_err++;
                        $display("FAIL pixel: act=%0h req=%0h", video, e);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        bus_a = a; bus_d = d; bus_wr = 1'b1;
        @(negedge clk);
        bus_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_data = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", {7'd0, byte_ready}, 8'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic exp_push(input logic [31:0] nibs, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(nibs[31 - 4*i -: 4]);
    endtask

    task automatic burst(input int n);
        mon_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_ce = 1'b1;
            @(negedge clk);
        end
        pix_ce = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
    endtask

    function automatic logic [3:0] map320(input logic [5:0] c, input logic [1:0] p);
        return (p == 2'd0) ? c[3:0] : {c[4], p, c[5]};
    endfunction

    task automatic stream(input logic [7:0] base, input int npix, input int exp_acc);
        int acc0;
        int n;
        acc0 = acc_cnt;
        n = 0;
        byte_data = base;
        byte_valid = 1'b1;
        while (acc_cnt == acc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        display_enable = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < npix; i++) begin
            pix_ce = 1'b1;
            byte_data = 8'(base + 8'(acc_cnt - acc0));
            @(negedge clk);
        end
        pix_ce = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        display_enable = 1'b0;
        check("stream_accepts", 8'(acc_cnt - acc0), 8'(exp_acc));
        check("stream_no_underrun", {7'd0, underrun}, 8'd0);
    endtask

    initial begin
        logic [7:0] b;
        @(negedge clk);
        do_reset();
        check("reset_video", {4'd0, video}, 8'd0);
        check("reset_ready", {7'd0, byte_ready}, 8'd0);
        check("reset_underrun", {7'd0, underrun}, 8'd0);
        wr(1'b0, 8'h0A);
        check("ready_after_mode", {7'd0, byte_ready}, 8'd1);

        // 320 mode, palette 1, background 1.
        wr(1'b1, 8'h21);
        push_byte(8'h1B);
        exp_push(32'h11335577, 8);
        display_enable = 1'b1;
        burst(8);
        display_enable = 1'b0;
        @(negedge clk);
        check("border_320", {4'd0, video}, 8'h01);
        check("no_underrun_320", {7'd0, underrun}, 8'd0);

        // 320 mode, palette 0 intense, background 0: pixels 3,2,1,0.
        wr(1'b1, 8'h10);
        push_byte(8'hE4);
        exp_push(32'hEECCAA00, 8);
        display_enable = 1'b1;
        burst(8);
        display_enable = 1'b0;
        @(negedge clk);

        // 640 mode.
        wr(1'b0, 8'h1A);
        wr(1'b1, 8'h0F);
        check("border_640", {4'd0, video}, 8'h00);
        push_byte(8'hA5);
        exp_push(32'hF0F00F0F, 8);
        display_enable = 1'b1;
        burst(8);

        // Underrun on the 9th pixel, flag sticky after data resumes.
        push_byte(8'hFF);
        exp_push(32'hFFFFFFFF, 8);
        exp_push(32'h00000000, 1);
        burst(9);
        check("underrun_set", {7'd0, underrun}, 8'd1);
        push_byte(8'h81);
        exp_push(32'hF000000F, 8);
        burst(8);
        check("underrun_sticky", {7'd0, underrun}, 8'd1);
        display_enable = 1'b0;
        @(negedge clk);
        check("de_low_640", {4'd0, video}, 8'h00);

        // Text mode border and video disable.
        wr(1'b1, 8'h05);
        wr(1'b0, 8'h08);
        check("text_border", {4'd0, video}, 8'h05);
        check("text_ready", {7'd0, byte_ready}, 8'd0);
        wr(1'b0, 8'h00);
        check("video_disable", {4'd0, video}, 8'h00);

        // Mode 5 (B/W bit set in 320 graphics).
        do_reset();
        wr(1'b0, 8'h0E);
        wr(1'b1, 8'h00);
        push_byte(8'h1B);
`ifdef CGA_MODE5_PALETTE_EN
        exp_push(32'h00334477, 8);
`else
        exp_push(32'h00224466, 8);
`endif
        display_enable = 1'b1;
        burst(8);
        display_enable = 1'b0;
        @(negedge clk);

        // Back-to-back 640: four bytes over 32 pixels, incrementing pattern.
        do_reset();
        wr(1'b0, 8'h1A);
        wr(1'b1, 8'h0F);
        for (int k = 0; k < 4; k++) begin
            b = 8'(8'h01 + k);
            for (int j = 7; j >= 0; j--) exp_q.push_back(b[j] ? 4'hF : 4'h0);
        end
        stream(8'h01, 32, 5);

        // Back-to-back 320: two bytes over 16 pix_ce.
        do_reset();
        wr(1'b0, 8'h0A);
        wr(1'b1, 8'h21);
        for (int k = 0; k < 2; k++) begin
            b = 8'(8'h31 + k);
            for (int j = 3; j >= 0; j--) begin
                exp_q.push_back(map320(6'h21, b[2*j +: 2]));
                exp_q.push_back(map320(6'h21, b[2*j +: 2]));
            end
        end
        stream(8'h31, 16, 3);

        @(negedge clk);
        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
